// File: rtl/casilla_n.sv
// One card cell of a memory game: reveal on a select edge, then match (sticky)
// or hold for SHOW_CYCLES enabled ticks before hiding again.
`timescale 1ns/1ps
module casilla_n #(
    parameter int LABEL_W     = 4,
    parameter int PLAYERS     = 2,
    parameter int PLAYER_W    = 1,
    parameter int SHOW_CYCLES = 8
) (
    input  logic                clk_Temp,
    input  logic                rst,
    input  logic [LABEL_W-1:0]  label,
    input  logic [PLAYER_W-1:0] player,
    input  logic                select,
    input  logic                par,
    input  logic                mismatch,
    input  logic                counter,
    output logic [LABEL_W-1:0]  new_state,
    output logic [1:0]          state_o,
    output logic [PLAYER_W-1:0] owner,
    output logic                revealed_o,
    output logic                matched_o
);

    localparam int TIMER_W = $clog2(SHOW_CYCLES) + 1;

    localparam logic [1:0] ST_HIDDEN  = 2'b00;
    localparam logic [1:0] ST_SHOWN   = 2'b01;
    localparam logic [1:0] ST_HOLD    = 2'b10;
    localparam logic [1:0] ST_MATCHED = 2'b11;

    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(SHOW_CYCLES - 1);

    // Saturating decrement keeps the hold timer from wrapping below zero.
    function automatic logic [TIMER_W-1:0] sat_dec(input logic [TIMER_W-1:0] t);
        if (t == '0)
            return '0;
        return t - TIMER_W'(1);
    endfunction

    logic                sel_q;
    logic                request;
    logic                player_ok;

    logic [1:0]          state_q,   state_d;
    logic [LABEL_W-1:0]  label_q,   label_d;
    logic [PLAYER_W-1:0] player_q,  player_d;
    logic [PLAYER_W-1:0] owner_q,   owner_d;
    logic [TIMER_W-1:0]  timer_q,   timer_d;
    logic                reveal_q,  reveal_d;
    logic                match_q,   match_d;

    assign request   = select & ~sel_q;
    assign player_ok = int'(player) < PLAYERS;

    always_comb begin
        state_d  = state_q;
        label_d  = label_q;
        player_d = player_q;
        owner_d  = owner_q;
        timer_d  = timer_q;
        reveal_d = 1'b0;
        match_d  = 1'b0;
        case (state_q)
            ST_HIDDEN: begin
                if (request && player_ok) begin
                    state_d  = ST_SHOWN;
                    label_d  = label;
                    player_d = player;
                    reveal_d = 1'b1;
                end
            end
            ST_SHOWN: begin
                // A simultaneous par and mismatch verdict resolves as a match.
                if (par) begin
                    state_d = ST_MATCHED;
                    owner_d = player_q;
                    match_d = 1'b1;
                end else if (mismatch) begin
                    state_d = ST_HOLD;
                    timer_d = TIMER_LOAD;
                end
            end
            ST_HOLD: begin
                // Loading SHOW_CYCLES-1 and leaving on the tick at zero gives
                // exactly SHOW_CYCLES enabled ticks of visibility.
                if (counter) begin
                    if (timer_q == '0) begin
                        state_d  = ST_HIDDEN;
                        label_d  = '0;
                        player_d = '0;
                    end else begin
                        timer_d = sat_dec(timer_q);
                    end
                end
            end
            default: begin
                state_d = ST_MATCHED;
            end
        endcase
    end

    always_ff @(posedge clk_Temp) begin
        if (rst) begin
            sel_q    <= 1'b1;
            state_q  <= ST_HIDDEN;
            label_q  <= '0;
            player_q <= '0;
            owner_q  <= '0;
            timer_q  <= '0;
            reveal_q <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            sel_q    <= select;
            state_q  <= state_d;
            label_q  <= label_d;
            player_q <= player_d;
            owner_q  <= owner_d;
            timer_q  <= timer_d;
            reveal_q <= reveal_d;
            match_q  <= match_d;
        end
    end

    assign new_state  = label_q;
    assign state_o    = state_q;
    assign owner      = owner_q;
    assign revealed_o = reveal_q;
    assign matched_o  = match_q;

endmodule

// File: tb/tb_casilla_n.sv
// Directed bench for casilla_n: expected outputs are queued with each stimulus
// step and popped for comparison one time unit after the clock edge.
`timescale 1ns/1ps
module tb_casilla_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] label = '0;
    logic [0:0] player = '0;
    logic       select = 1'b1;
    logic       par = 1'b0;
    logic       mismatch = 1'b0;
    logic       counter = 1'b0;
    logic [3:0] new_state;
    logic [1:0] state_o;
    logic [0:0] owner;
    logic       revealed_o;
    logic       matched_o;

    logic [3:0] label3 = '0;
    logic [1:0] player3 = '0;
    logic       select3 = 1'b0;
    logic [3:0] new_state3;
    logic [1:0] state3;
    logic [1:0] owner3;
    logic       revealed3;
    logic       matched3;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         which;
        logic [1:0] st;
        logic [3:0] ns;
        logic [1:0] own;
        logic       rev;
        logic       mat;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    casilla_n #(.LABEL_W(4), .PLAYERS(2), .PLAYER_W(1), .SHOW_CYCLES(3)) dut (
        .clk_Temp(clk), .rst(rst), .label(label), .player(player),
        .select(select), .par(par), .mismatch(mismatch), .counter(counter),
        .new_state(new_state), .state_o(state_o), .owner(owner),
        .revealed_o(revealed_o), .matched_o(matched_o)
    );

    casilla_n #(.LABEL_W(4), .PLAYERS(3), .PLAYER_W(2), .SHOW_CYCLES(3)) dut3 (
        .clk_Temp(clk), .rst(rst), .label(label3), .player(player3),
        .select(select3), .par(1'b0), .mismatch(1'b0), .counter(1'b0),
        .new_state(new_state3), .state_o(state3), .owner(owner3),
        .revealed_o(revealed3), .matched_o(matched3)
    );

    task automatic chk(input string tag, input string field,
                       input logic [7:0] got, input logic [7:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s %s got=%0h exp=%0h", tag, field, got, want);
        end
    endtask

    task automatic compare_next();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard empty");
            return;
        end
        e = sb.pop_front();
        if (e.which == 0) begin
            chk(e.tag, "state_o",    {6'd0, state_o},    {6'd0, e.st});
            chk(e.tag, "new_state",  {4'd0, new_state},  {4'd0, e.ns});
            chk(e.tag, "owner",      {7'd0, owner},      {6'd0, e.own});
            chk(e.tag, "revealed_o", {7'd0, revealed_o}, {7'd0, e.rev});
            chk(e.tag, "matched_o",  {7'd0, matched_o},  {7'd0, e.mat});
        end else begin
            chk(e.tag, "state_o",    {6'd0, state3},     {6'd0, e.st});
            chk(e.tag, "new_state",  {4'd0, new_state3}, {4'd0, e.ns});
            chk(e.tag, "owner",      {6'd0, owner3},     {6'd0, e.own});
            chk(e.tag, "revealed_o", {7'd0, revealed3},  {7'd0, e.rev});
        end
    endtask

    // Drive the main cell for one clock and check its registered response.
    task automatic step(input logic r, input logic s, input logic [3:0] lb,
                        input logic [0:0] pl, input logic p, input logic mm,
                        input logic cnt, input logic [1:0] es, input logic [3:0] en,
                        input logic [1:0] eo, input logic er, input logic em,
                        input string tag);
        exp_t e;
        e.which = 0; e.st = es; e.ns = en; e.own = eo; e.rev = er; e.mat = em; e.tag = tag;
        sb.push_back(e);
        rst = r; select = s; label = lb; player = pl;
        par = p; mismatch = mm; counter = cnt;
        @(posedge clk);
        #1;
        compare_next();
    endtask

    task automatic step3(input logic s, input logic [1:0] pl, input logic [3:0] lb,
                         input logic [1:0] es, input logic [3:0] en, input logic er,
                         input string tag);
        exp_t e;
        e.which = 1; e.st = es; e.ns = en; e.own = 2'd0; e.rev = er; e.mat = 1'b0; e.tag = tag;
        sb.push_back(e);
        rst = 1'b0; select3 = s; player3 = pl; label3 = lb;
        @(posedge clk);
        #1;
        compare_next();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with select held high, then keep it high: no request
        step(1, 1, 4'd0, 1'd0, 0, 0, 0, 2'b00, 4'd0, 2'd0, 0, 0, "rst_sel_hi");
        for (int i = 0; i < 10; i++)
            step(0, 1, 4'd8, 1'd1, 0, 0, 0, 2'b00, 4'd0, 2'd0, 0, 0, "sel_held");

        // reveal label 8 by player 1
        step(0, 0, 4'd8, 1'd1, 0, 0, 0, 2'b00, 4'd0, 2'd0, 0, 0, "sel_low");
        step(0, 1, 4'd8, 1'd1, 0, 0, 0, 2'b01, 4'd8, 2'd0, 1, 0, "reveal");
        step(0, 0, 4'd3, 1'd0, 0, 0, 0, 2'b01, 4'd8, 2'd0, 0, 0, "shown_pulse_end");
        step(0, 1, 4'd3, 1'd0, 0, 0, 1, 2'b01, 4'd8, 2'd0, 0, 0, "shown_sel_ign");
        step(0, 0, 4'd5, 1'd0, 0, 0, 0, 2'b01, 4'd8, 2'd0, 0, 0, "shown_lbl_ign");

        // match, then everything but reset is ignored
        step(0, 0, 4'd5, 1'd0, 1, 0, 0, 2'b11, 4'd8, 2'd1, 0, 1, "match");
        for (int i = 0; i < 20; i++)
            step(0, i[0], 4'(i), i[2], i[1], 1, 1, 2'b11, 4'd8, 2'd1, 0, 0, "matched_sticky");

        // reset clears a matched cell
        step(1, 0, 4'd0, 1'd0, 0, 0, 0, 2'b00, 4'd0, 2'd0, 0, 0, "rst_matched");

        // mismatch with counter every cycle: hidden after 3 ticks
        step(0, 0, 4'd5, 1'd0, 0, 0, 0, 2'b00, 4'd0, 2'd0, 0, 0, "idle");
        step(0, 1, 4'd5, 1'd0, 0, 0, 0, 2'b01, 4'd5, 2'd0, 1, 0, "reveal5");
        step(0, 0, 4'd5, 1'd0, 0, 1, 1, 2'b10, 4'd5, 2'd0, 0, 0, "hold_enter");
        step(0, 1, 4'd5, 1'd0, 1, 0, 1, 2'b10, 4'd5, 2'd0, 0, 0, "hold_tick1");
        step(0, 0, 4'd5, 1'd0, 0, 1, 1, 2'b10, 4'd5, 2'd0, 0, 0, "hold_tick2");
        step(0, 0, 4'd5, 1'd0, 0, 0, 1, 2'b00, 4'd0, 2'd0, 0, 0, "hold_tick3_hide");

        // mismatch with counter every other cycle: hidden on the sixth cycle
        step(0, 1, 4'd9, 1'd1, 0, 0, 0, 2'b01, 4'd9, 2'd0, 1, 0, "reveal9");
        step(0, 0, 4'd9, 1'd1, 0, 1, 0, 2'b10, 4'd9, 2'd0, 0, 0, "hold2_enter");
        for (int i = 0; i < 5; i++)
            step(0, 0, 4'd9, 1'd1, 0, 0, i[0], 2'b10, 4'd9, 2'd0, 0, 0, "hold2_wait");
        step(0, 0, 4'd9, 1'd1, 0, 0, 1, 2'b00, 4'd0, 2'd0, 0, 0, "hold2_hide");

        // par and mismatch together: par wins
        step(0, 1, 4'd6, 1'd0, 0, 0, 0, 2'b01, 4'd6, 2'd0, 1, 0, "reveal6");
        step(0, 0, 4'd6, 1'd0, 1, 1, 0, 2'b11, 4'd6, 2'd0, 0, 1, "par_wins");
        step(0, 0, 4'd6, 1'd0, 0, 0, 0, 2'b11, 4'd6, 2'd0, 0, 0, "par_wins_hold");

        // reset in the middle of a hold with timer at 1
        step(1, 0, 4'd0, 1'd0, 0, 0, 0, 2'b00, 4'd0, 2'd0, 0, 0, "rst_matched2");
        step(0, 0, 4'd2, 1'd1, 0, 0, 0, 2'b00, 4'd0, 2'd0, 0, 0, "idle2");
        step(0, 1, 4'd2, 1'd1, 0, 0, 0, 2'b01, 4'd2, 2'd0, 1, 0, "reveal2");
        step(0, 0, 4'd2, 1'd1, 0, 1, 0, 2'b10, 4'd2, 2'd0, 0, 0, "hold3_enter");
        step(0, 0, 4'd2, 1'd1, 0, 0, 1, 2'b10, 4'd2, 2'd0, 0, 0, "hold3_t1");
        step(1, 0, 4'd2, 1'd1, 0, 0, 1, 2'b00, 4'd0, 2'd0, 0, 0, "rst_in_hold");

        // three-player cell: out-of-range player index is rejected
        step3(0, 2'd3, 4'd7, 2'b00, 4'd0, 0, "p3_idle");
        step3(1, 2'd3, 4'd7, 2'b00, 4'd0, 0, "p3_bad_player");
        step3(0, 2'd3, 4'd7, 2'b00, 4'd0, 0, "p3_idle2");
        step3(1, 2'd2, 4'd7, 2'b01, 4'd7, 1, "p3_good_player");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/casilla_n.md
CASILLA_N -- requirements
Module: casilla_n

Interface
REQ-001 Parameter LABEL_W, default 4: card label width in bits, min 1.
REQ-002 Parameter PLAYERS, default 2: number of players, min 2.
REQ-003 Parameter PLAYER_W, default 1: player index width; SHALL equal clog2(PLAYERS).
REQ-004 Parameter SHOW_CYCLES, default 8: enabled ticks a mismatched card stays visible before hiding, min 1.
REQ-005 clk_Temp  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset, sampled on clk_Temp rising edge.
REQ-007 label  in  LABEL_W  card face value, captured at reveal.
REQ-008 player  in  PLAYER_W  index of the player currently selecting.
REQ-009 select  in  1  level input; only its rising edge is a selection request.
REQ-010 par  in  1  controller verdict: the revealed pair matches.
REQ-011 mismatch  in  1  controller verdict: the revealed pair does not match.
REQ-012 counter  in  1  timer tick enable for the hold countdown.
REQ-013 new_state  out  LABEL_W  displayed face: captured label when visible, else 0.
REQ-014 state_o  out  2  cell state code: HIDDEN=00, SHOWN=01, HOLD=10, MATCHED=11.
REQ-015 owner  out  PLAYER_W  player credited with the match; 0 unless MATCHED.
REQ-016 revealed_o  out  1  one-cycle pulse on the HIDDEN->SHOWN transition.
REQ-017 matched_o  out  1  one-cycle pulse on the SHOWN->MATCHED transition.

Function
REQ-018 Edge detect: sel_q SHALL register select each cycle; request = select & ~sel_q.
REQ-019 HIDDEN: on request with player < PLAYERS -> SHOWN next cycle; capture label and player; revealed_o=1 in that cycle.
REQ-020 HIDDEN: on request with player >= PLAYERS -> stay HIDDEN, no capture, no pulse.
REQ-021 SHOWN: par=1 -> MATCHED; owner <= captured player; matched_o=1 for one cycle.
REQ-022 SHOWN: mismatch=1 and par=0 -> HOLD; timer loaded with SHOW_CYCLES-1.
REQ-023 SHOWN: par and mismatch both 1 -> par wins (MATCHED).
REQ-024 SHOWN: select edges ignored; label changes do not alter new_state.
REQ-025 HOLD: each cycle with counter=1 and timer>0 decrements timer; counter=0 holds it.
REQ-026 HOLD: counter=1 with timer==0 -> HIDDEN next cycle; captured label cleared to 0.
REQ-027 HOLD: par, mismatch and select edges ignored; visible time = exactly SHOW_CYCLES enabled ticks.
REQ-028 MATCHED: sticky until rst; all inputs except rst ignored.
REQ-029 new_state = captured label in SHOWN, HOLD, MATCHED; 0 in HIDDEN.
REQ-030 Timer width = clog2(SHOW_CYCLES)+1 bits; no underflow (never decrements below 0).
REQ-031 Outputs registered; no combinational path from any input to any output.

Reset
REQ-032 rst=1 at a rising edge -> state HIDDEN, new_state=0, owner=0, timer=0, revealed_o=0, matched_o=0.
REQ-033 sel_q SHALL reset to 1 so select held high through reset release is not a request.
REQ-034 rst SHALL override any in-progress state (SHOWN, HOLD, MATCHED) in the same edge.

Verification (LABEL_W=4, PLAYERS=2, SHOW_CYCLES=3)
REQ-035 Reset with select=1, then hold select=1 10 cycles -> state_o=00, new_state=0, no revealed_o.
REQ-036 label=4'b1000, player=1, select 0->1 -> next cycle state_o=01, new_state=8, revealed_o=1 for one cycle; later select toggles ignored.
REQ-037 From SHOWN, par=1 -> state_o=11, owner=1, matched_o one cycle; further select/mismatch/par ignored for 20 cycles.
REQ-038 From SHOWN, mismatch=1, counter=1 every cycle -> HOLD, then HIDDEN after exactly 3 ticks, new_state=0; with counter=1 every other cycle -> 6 cycles.
REQ-039 From SHOWN, par=1 and mismatch=1 same cycle -> state_o=11; player=3 with PLAYER_W=2, PLAYERS=3 request -> stays 00.
REQ-040 rst=1 while in HOLD with timer=1 -> next cycle state_o=00, new_state=0, owner=0.
